eth_tx_sched: RTL and testbench
===============================

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 Parameter IFG_CYCLES, default 12, is the number of idle cycles inserted after each frame (inter-frame gap).
REQ-002 Parameter DONE_TIMEOUT, default 4096, is the maximum cycles in WAIT_DONE before the frame is abandoned.
REQ-003 aclk  input  1  single clock; all logic is rising-edge.
REQ-004 aresetn  input  1  reset, asynchronous and active-low.
REQ-005 arp_req  input  1  one-cycle pulse: an ARP reply is required.
REQ-006 arp_req_mac  input  48  requester MAC, valid with arp_req.
REQ-007 udp_frame_rdy  input  1  level: at least one complete UDP frame is buffered for transmit.
REQ-008 udp_mac_d  input  48  destination MAC for UDP frames, sampled at grant.
REQ-009 tx_done  input  1  one-cycle pulse from the frame builder: current frame fully sent.
REQ-010 tx_start  output  1  one-cycle pulse: the builder starts a frame.
REQ-011 tx_sel  output  1  frame type of current grant: 0 = UDP, 1 = ARP.
REQ-012 tx_mac_d  output  48  destination MAC of current grant.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 arp_drop  output  1  one-cycle pulse: an ARP request was discarded.
REQ-015 timeout_err  output  1  one-cycle pulse: tx_done was not received within DONE_TIMEOUT.

Function
REQ-016 FSM states are IDLE, START, WAIT_DONE and IFG, with IDLE as the reset state.
REQ-017 ARP pending: a 1-deep register (arp_pend flag and 48-bit MAC) is set on arp_req and captures arp_req_mac.
REQ-018 If arp_req arrives while arp_pend is already set and is not being cleared in the same cycle, the new request is discarded, the stored MAC is kept, and arp_drop pulses in the following cycle.
REQ-019 arp_pend clears on the IDLE->START edge that grants ARP; an arp_req in that same cycle re-sets arp_pend with the new MAC (set wins) and does not cause a drop.
REQ-020 IDLE: if arp_pend or udp_frame_rdy is set, the FSM goes to START on the next edge, latching tx_sel and tx_mac_d; otherwise it stays in IDLE.
REQ-021 Arbitration: ARP has priority, except when the previous grant was ARP and udp_frame_rdy is high, in which case UDP is granted.
REQ-022 Arbitration history: a last_arp register updates on every grant; its reset value is 0.
REQ-023 START lasts exactly one cycle with tx_start = 1, then the FSM goes to WAIT_DONE.
REQ-024 tx_sel and tx_mac_d are held stable from START until IFG exit.
REQ-025 WAIT_DONE: on tx_done the FSM goes to IFG.
REQ-026 Timeout counter: it counts cycles in WAIT_DONE; when the count reaches DONE_TIMEOUT-1 without tx_done, timeout_err pulses and the FSM goes to IFG.
REQ-027 tx_done in the same cycle as the timeout terminal count counts as done: no timeout_err is raised.
REQ-028 tx_done outside WAIT_DONE, including during START, is ignored.
REQ-029 IFG: the FSM stays for exactly IFG_CYCLES cycles, then goes to IDLE; requests arriving in IFG remain pending.
REQ-030 Latency: an arp_req in cycle N with the FSM idle gives tx_start high in cycle N+2.
REQ-031 Back-to-back frames: tx_done to the next tx_start is IFG_CYCLES+2 cycles.
REQ-032 Counters are sized $clog2 of their parameter, saturate at no value, and reload to 0 on every state entry.
REQ-033 arp_req continues to be captured in all states.

Reset
REQ-034 Asserting aresetn low immediately forces: state IDLE, arp_pend 0, last_arp 0, counters 0, tx_start 0, tx_sel 0, tx_mac_d 0, busy 0, arp_drop 0, timeout_err 0.
REQ-035 Reset asserted mid-frame abandons the grant; after release, no tx_start is produced until a new request or a still-high udp_frame_rdy is present.

Verification
REQ-036 Single ARP: arp_req with MAC 0x0A1B2C3D4E5F in cycle 10 -> tx_start in cycle 12, tx_sel=1, tx_mac_d=0x0A1B2C3D4E5F, busy=1.
REQ-037 Contention: arp_req pulsed every frame while udp_frame_rdy is held high -> grants alternate ARP, UDP, ARP, UDP (first grant is ARP).
REQ-038 Drop: two arp_req pulses while WAIT_DONE is active -> the first is kept, arp_drop pulses once, and the next ARP grant uses the first MAC.
REQ-039 Timeout: tx_done is never sent and DONE_TIMEOUT=16 -> timeout_err pulses 16 cycles after WAIT_DONE entry, followed by 12 IFG cycles, then IDLE.
REQ-040 Gap: tx_done in cycle 100 with udp_frame_rdy high -> IFG covers cycles 101..112 and the next tx_start is in cycle 114.
REQ-041 Reset mid-frame: aresetn low during WAIT_DONE -> all outputs are 0 immediately, and with no requests after release tx_start stays low.

Source files
------------

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - ARP/UDP transmit arbiter with inter-frame gap and tx_done timeout
// One frame in flight at a time; a single ARP reply can wait while a frame is being sent.
module eth_tx_sched #(
  parameter int IFG_CYCLES   = 12,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        arp_req,
  input  logic [47:0] arp_req_mac,
  input  logic        udp_frame_rdy,
  input  logic [47:0] udp_mac_d,
  input  logic        tx_done,
  output logic        tx_start,
  output logic        tx_sel,
  output logic [47:0] tx_mac_d,
  output logic        busy,
  output logic        arp_drop,
  output logic        timeout_err
);

  localparam int TO_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    IFG
  } state_t;

  state_t            state_q;
  logic              arp_pend_q;
  logic [47:0]       arp_mac_q;
  logic              last_arp_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [IFG_W-1:0]  ifg_cnt_q;
  logic              tx_start_q;
  logic              tx_sel_q;
  logic [47:0]       tx_mac_q;
  logic              busy_q;
  logic              arp_drop_q;
  logic              timeout_err_q;

  logic grant_any;
  logic grant_arp;
  logic arp_clear;

  // ARP wins unless it also won last time and UDP is waiting, so neither starves.
  assign grant_any = arp_pend_q | udp_frame_rdy;
  assign grant_arp = arp_pend_q & ~(last_arp_q & udp_frame_rdy);
  assign arp_clear = (state_q == IDLE) & grant_arp;

  // A request arriving on the cycle the pending one is granted refills the slot instead of dropping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arp_pend_q <= 1'b0;
      arp_mac_q  <= '0;
      arp_drop_q <= 1'b0;
    end else begin
      arp_drop_q <= arp_req & arp_pend_q & ~arp_clear;
      if (arp_req && (!arp_pend_q || arp_clear)) begin
        arp_pend_q <= 1'b1;
        arp_mac_q  <= arp_req_mac;
      end else if (arp_clear) begin
        arp_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      last_arp_q    <= 1'b0;
      to_cnt_q      <= '0;
      ifg_cnt_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_sel_q      <= 1'b0;
      tx_mac_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q    <= START;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            tx_sel_q   <= grant_arp;
            tx_mac_q   <= grant_arp ? arp_mac_q : udp_mac_d;
            last_arp_q <= grant_arp;
            to_cnt_q   <= '0;
            ifg_cnt_q  <= '0;
          end
        end
        START: begin
          state_q  <= WAIT_DONE;
          to_cnt_q <= '0;
        end
        WAIT_DONE: begin
          // A done arriving on the terminal count still counts as a normal completion.
          if (tx_done) begin
            state_q   <= IFG;
            to_cnt_q  <= '0;
            ifg_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= IFG;
            timeout_err_q <= 1'b1;
            to_cnt_q      <= '0;
            ifg_cnt_q     <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        IFG: begin
          if (ifg_cnt_q == IFG_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ifg_cnt_q <= '0;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IFG_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_sel      = tx_sel_q;
  assign tx_mac_d    = tx_mac_q;
  assign busy        = busy_q;
  assign arp_drop    = arp_drop_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - self-checking bench for eth_tx_sched
// Expected grants are queued as stimulus is applied and popped by a monitor on each tx_start.
module tb_eth_tx_sched;

  localparam int IFG = 12;
  localparam int TO  = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        arp_req = 1'b0;
  logic [47:0] arp_req_mac = '0;
  logic        udp_frame_rdy = 1'b0;
  logic [47:0] udp_mac_d = '0;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic        tx_sel;
  logic [47:0] tx_mac_d;
  logic        busy;
  logic        arp_drop;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  int start_cnt = 0;
  logic [48:0] sb_q[$];
  logic [48:0] sb_want;

  typedef struct {
    logic        arp;
    logic [47:0] amac;
    logic        udp;
    logic [47:0] umac;
    logic [48:0] want0;
    logic        two;
    logic [48:0] want1;
  } vec_t;

  vec_t vecs[6];

  eth_tx_sched #(.IFG_CYCLES(IFG), .DONE_TIMEOUT(TO)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .arp_req(arp_req),
    .arp_req_mac(arp_req_mac),
    .udp_frame_rdy(udp_frame_rdy),
    .udp_mac_d(udp_mac_d),
    .tx_done(tx_done),
    .tx_start(tx_start),
    .tx_sel(tx_sel),
    .tx_mac_d(tx_mac_d),
    .busy(busy),
    .arp_drop(arp_drop),
    .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (arp_drop) drop_cnt++;
      if (tx_start) begin
        start_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_tx_start", {tx_sel, tx_mac_d}, 64'h0);
        end else begin
          sb_want = sb_q.pop_front();
          check("grant_sel_mac", {15'h0, tx_sel, tx_mac_d}, {15'h0, sb_want});
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_start(input string name, output int n);
    n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    check(name, tx_start, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input string name);
    int m;
    tick();
    pulse_done();
    wait_idle(m);
    check(name, m, IFG);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int s0;
    vecs[0] = '{1'b1, 48'hA0A0_0000_0001, 1'b0, 48'h0,             {1'b1, 48'hA0A0_0000_0001}, 1'b0, 49'h0};
    vecs[1] = '{1'b1, 48'hB0B0_0000_0002, 1'b1, 48'hC1C1_0000_0011, {1'b0, 48'hC1C1_0000_0011}, 1'b1, {1'b1, 48'hB0B0_0000_0002}};
    vecs[2] = '{1'b0, 48'h0,             1'b1, 48'hC2C2_0000_0012, {1'b0, 48'hC2C2_0000_0012}, 1'b0, 49'h0};
    vecs[3] = '{1'b1, 48'hB3B3_0000_0003, 1'b1, 48'hC3C3_0000_0013, {1'b1, 48'hB3B3_0000_0003}, 1'b0, 49'h0};
    vecs[4] = '{1'b1, 48'hB4B4_0000_0004, 1'b1, 48'hC4C4_0000_0014, {1'b0, 48'hC4C4_0000_0014}, 1'b1, {1'b1, 48'hB4B4_0000_0004}};
    vecs[5] = '{1'b1, 48'hB5B5_0000_0005, 1'b1, 48'hC5C5_0000_0015, {1'b0, 48'hC5C5_0000_0015}, 1'b1, {1'b1, 48'hB5B5_0000_0005}};

    #2 aresetn = 1'b0;
    #1;
    check("reset_outputs_async", {tx_start, tx_sel, busy, arp_drop, timeout_err, tx_mac_d}, 64'h0);
    repeat (3) tick();
    check("reset_outputs_held", {tx_start, tx_sel, busy, arp_drop, timeout_err, tx_mac_d}, 64'h0);
    aresetn = 1'b1;
    repeat (5) tick();
    check("idle_after_reset", {tx_start, busy}, 64'h0);

    // single ARP: request in cycle N, tx_start in N+2
    sb_q.push_back({1'b1, 48'h0A1B_2C3D_4E5F});
    arp_req = 1'b1;
    arp_req_mac = 48'h0A1B_2C3D_4E5F;
    tick();
    arp_req = 1'b0;
    check("arp_lat_n1", {tx_start, busy}, 64'h0);
    tick();
    check("arp_lat_n2_start", tx_start, 1);
    check("arp_busy", busy, 1);
    check("arp_sel_mac", {tx_sel, tx_mac_d}, {1'b1, 48'h0A1B_2C3D_4E5F});
    tick();
    check("start_one_cycle", tx_start, 0);
    pulse_done();
    wait_idle(m);
    check("arp_ifg_len", m, IFG);

    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(vecs[i].want0);
      if (vecs[i].two) sb_q.push_back(vecs[i].want1);
      arp_req = vecs[i].arp;
      arp_req_mac = vecs[i].amac;
      udp_mac_d = vecs[i].umac;
      tick();
      arp_req = 1'b0;
      udp_frame_rdy = vecs[i].udp;
      wait_start("vec_start", n);
      udp_frame_rdy = 1'b0;
      run_frame("vec_ifg");
      if (vecs[i].two) begin
        wait_start("vec_start2", n);
        run_frame("vec_ifg2");
      end
    end
    check("vec_sb_drained", sb_q.size(), 0);

    // two ARP requests during WAIT_DONE: first kept, second dropped
    s0 = drop_cnt;
    sb_q.push_back({1'b0, 48'hD6D6_0000_0016});
    udp_mac_d = 48'hD6D6_0000_0016;
    udp_frame_rdy = 1'b1;
    wait_start("drop_udp_start", n);
    udp_frame_rdy = 1'b0;
    tick();
    sb_q.push_back({1'b1, 48'hE1E1_0000_0021});
    arp_req = 1'b1;
    arp_req_mac = 48'hE1E1_0000_0021;
    tick();
    arp_req_mac = 48'hF1F1_0000_0031;
    tick();
    arp_req = 1'b0;
    check("arp_drop_pulse", arp_drop, 1);
    tick();
    check("arp_drop_one_cycle", arp_drop, 0);
    pulse_done();
    wait_idle(m);
    // request in the same cycle the pending ARP is granted: refills, no drop
    sb_q.push_back({1'b1, 48'h1212_0000_0041});
    arp_req = 1'b1;
    arp_req_mac = 48'h1212_0000_0041;
    tick();
    arp_req = 1'b0;
    wait_start("drop_arp_start", n);
    run_frame("drop_arp_ifg");
    wait_start("refill_arp_start", n);
    run_frame("refill_arp_ifg");
    check("drop_count", drop_cnt - s0, 1);

    // back-to-back UDP: tx_done to next tx_start is IFG+2; MAC held across the frame
    sb_q.push_back({1'b0, 48'h7777_0000_0051});
    sb_q.push_back({1'b0, 48'h8888_0000_0052});
    udp_mac_d = 48'h7777_0000_0051;
    udp_frame_rdy = 1'b1;
    wait_start("gap_start1", n);
    tick();
    udp_mac_d = 48'h8888_0000_0052;
    tick();
    check("mac_held_in_wait", tx_mac_d, 48'h7777_0000_0051);
    pulse_done();
    wait_start("gap_start2", n);
    check("gap_done_to_start", n + 1, IFG + 2);
    udp_frame_rdy = 1'b0;
    run_frame("gap_ifg");

    // timeout with no tx_done
    sb_q.push_back({1'b0, 48'h9999_0000_0061});
    udp_mac_d = 48'h9999_0000_0061;
    udp_frame_rdy = 1'b1;
    wait_start("to_start", n);
    udp_frame_rdy = 1'b0;
    tick();
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_busy", busy, 1);
    tick();
    check("timeout_one_cycle", timeout_err, 0);
    wait_idle(m);
    check("timeout_ifg_rest", m, IFG - 1);

    // tx_done on the terminal count is a normal completion
    sb_q.push_back({1'b0, 48'hAAAA_0000_0071});
    udp_mac_d = 48'hAAAA_0000_0071;
    udp_frame_rdy = 1'b1;
    wait_start("term_start", n);
    udp_frame_rdy = 1'b0;
    tick();
    repeat (TO - 1) tick();
    pulse_done();
    check("term_no_timeout", {busy, timeout_err}, 64'h2);
    wait_idle(m);
    check("term_ifg_len", m, IFG);

    // tx_done during START is ignored
    sb_q.push_back({1'b0, 48'hBBBB_0000_0081});
    udp_mac_d = 48'hBBBB_0000_0081;
    udp_frame_rdy = 1'b1;
    wait_start("ign_start", n);
    udp_frame_rdy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (4) tick();
    check("ign_still_busy", busy, 1);
    pulse_done();
    wait_idle(m);
    check("ign_ifg_len", m, IFG);

    // reset mid-frame
    sb_q.push_back({1'b1, 48'hCCCC_0000_0091});
    arp_req = 1'b1;
    arp_req_mac = 48'hCCCC_0000_0091;
    tick();
    arp_req = 1'b0;
    wait_start("rst_start", n);
    tick();
    tick();
    check("rst_pre_sel", {busy, tx_sel}, 64'h3);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_outputs", {tx_start, tx_sel, busy, arp_drop, timeout_err, tx_mac_d}, 64'h0);
    tick();
    aresetn = 1'b1;
    s0 = start_cnt;
    repeat (20) tick();
    check("rst_no_restart", start_cnt - s0, 0);
    check("rst_idle", busy, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
